// File: rtl/usb_ep_status_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_ep_status_pkg: opcodes, clear-sweep states and the RMW apply function
// Rev 1.0
// ---------------------------------------------------------------------------
package usb_ep_status_pkg;

  localparam int MAX_DW = 64;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Callers zero-extend to MAX_DW and truncate the result back to their width.
  function automatic logic [MAX_DW-1:0] op_apply(input logic [MAX_DW-1:0] old,
                                                 input logic [MAX_DW-1:0] din,
                                                 input logic [1:0]        op);
    logic [MAX_DW-1:0] res;
    case (op)
      OP_WRITE: res = din;
      OP_SET:   res = old | din;
      OP_CLR:   res = old & ~din;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_ep_status_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_ep_status_ram: 1R1W synchronous RAM, read-before-write on same address
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_ep_status_ram
  import usb_ep_status_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

`ifdef USB_ARCH_ICE40
  (* ram_style = "block" *) logic [DW-1:0] mem [0:(1<<AW)-1];
`else
  logic [DW-1:0] mem [0:(1<<AW)-1];
`endif

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_ep_status_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_ep_status_mp: N-port endpoint status table with atomic RMW and clear sweep
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_ep_status_mp
  import usb_ep_status_pkg::*;
#(
  parameter int N_PORTS        = 2,
  parameter int AW             = 8,
  parameter int DW             = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PORTS-1:0]    req,
  input  logic [2*N_PORTS-1:0]  op,
  input  logic [N_PORTS-1:0]    zero,
  input  logic [AW*N_PORTS-1:0] addr,
  input  logic [DW*N_PORTS-1:0] din,
  output logic [N_PORTS-1:0]    ready,
  output logic [DW*N_PORTS-1:0] dout,
  output logic [N_PORTS-1:0]    dout_valid,
  output logic                  busy
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic          accept;
  logic [PW-1:0] gnt;
  logic          arb_blocked;

  // Fixed priority: a port is blocked by any lower-index request.
  always_comb begin
    ready       = '0;
    accept      = 1'b0;
    gnt         = '0;
    arb_blocked = busy;
    for (int i = 0; i < N_PORTS; i++) begin
      ready[i] = ~arb_blocked;
      if (req[i] && !arb_blocked) begin
        accept = 1'b1;
        gnt    = PW'(i);
      end
      arb_blocked = arb_blocked | req[i];
    end
  end

  logic          s1_valid;
  logic [PW-1:0] s1_port;
  logic [1:0]    s1_op;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_din;
  logic          s1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    if (accept) begin
      s1_port <= gnt;
      s1_op   <= op[2*gnt +: 2];
      s1_addr <= addr[AW*gnt +: AW];
      s1_din  <= din[DW*gnt +: DW];
      s1_zero <= zero[gnt];
    end
  end

  logic          s2_valid;
  logic [PW-1:0] s2_port;
  logic [1:0]    s2_op;
  logic [AW-1:0] s2_addr;
  logic [DW-1:0] s2_din;
  logic          s2_zero;
  logic          byp_valid;
  logic [DW-1:0] byp_data;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] old_2;
  logic [DW-1:0] new_2;
  logic [DW-1:0] ret_2;
  logic          we_2;

  assign old_2 = byp_valid ? byp_data : ram_q;
  assign new_2 = DW'(op_apply(MAX_DW'(old_2), MAX_DW'(s2_din), s2_op));
  assign ret_2 = s2_zero ? '0 : old_2;
  assign we_2  = s2_valid & (s2_op != OP_READ) & ~rst;

  // The RAM read issued alongside an S2 write to the same word returns the
  // stale value, so the fresh result is forwarded into the next S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      byp_valid <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      byp_valid <= s1_valid & we_2 & (s1_addr == s2_addr);
    end
    byp_data <= new_2;
    s2_port  <= s1_port;
    s2_op    <= s1_op;
    s2_addr  <= s1_addr;
    s2_din   <= s1_din;
    s2_zero  <= s1_zero;
  end

  logic [N_PORTS-1:0][DW-1:0] dout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r     <= '0;
      dout_valid <= '0;
    end else begin
      dout_valid <= '0;
      if (s2_valid) begin
        dout_valid[s2_port] <= 1'b1;
        dout_r[s2_port]     <= ret_2;
      end
    end
  end

  assign dout = dout_r;

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      clr_state_t    state;
      clr_state_t    state_nxt;
      logic [AW-1:0] cnt;
      logic [AW-1:0] cnt_nxt;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
          ST_IDLE: state_nxt = ST_IDLE;
          ST_CLEAR: begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == {AW{1'b1}}) begin
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end

      assign busy     = (state == ST_CLEAR);
      assign clr_we   = busy;
      assign clr_addr = cnt;
    end else begin : g_no_clear
      assign busy     = 1'b0;
      assign clr_we   = 1'b0;
      assign clr_addr = '0;
    end
  endgenerate

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  assign ram_we    = clr_we | we_2;
  assign ram_waddr = clr_we ? clr_addr : s2_addr;
  assign ram_wdata = clr_we ? '0 : new_2;

  usb_ep_status_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (s1_valid),
    .raddr(s1_addr),
    .rdata(ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_status_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usb_ep_status_mp: randomized self-checking bench with a word-array model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_usb_ep_status_mp;
  import usb_ep_status_pkg::*;

  localparam int NP = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req = '0;
  logic [2*NP-1:0]   op = '0;
  logic [NP-1:0]     zero = '0;
  logic [AW*NP-1:0]  addr = '0;
  logic [DW*NP-1:0]  din = '0;
  logic [NP-1:0]     ready;
  logic [DW*NP-1:0]  dout;
  logic [NP-1:0]     dout_valid;
  logic              busy;

  usb_ep_status_mp #(
    .N_PORTS(NP), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .zero(zero), .addr(addr),
    .din(din), .ready(ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          port;
    logic [DW-1:0] data;
  } cpl_t;

  cpl_t obs_q[$];
  cpl_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic [DW-1:0] mem_m [0:(1<<AW)-1];

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (dout_valid[p] === 1'b1) begin
        cpl_t e;
        e.cyc  = cyc;
        e.port = p;
        e.data = dout[p*DW +: DW];
        obs_q.push_back(e);
      end
    end
  end

  // Reference: serial execution of each granted op on a plain word array.
  function automatic logic [DW-1:0] model_op(logic [1:0] o, int a, logic [DW-1:0] d, logic z);
    logic [DW-1:0] old;
    old = mem_m[a];
    if (o == OP_WRITE) mem_m[a] = d;
    else if (o == OP_SET) mem_m[a] = old | d;
    else if (o == OP_CLR) mem_m[a] = old & ~d;
    return z ? '0 : old;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, logic [1:0] o, logic [AW-1:0] a, logic [DW-1:0] d, logic z, logic r);
    op[2*p +: 2]    = o;
    addr[AW*p +: AW] = a;
    din[DW*p +: DW]  = d;
    zero[p]         = z;
    req[p]          = r;
  endtask

  task automatic push_exp(int c, int p, logic [DW-1:0] v);
    cpl_t e;
    e.cyc  = c;
    e.port = p;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Uncontended single-cycle request; records the model's expected completion.
  task automatic issue(int p, logic [1:0] o, logic [AW-1:0] a, logic [DW-1:0] d, logic z);
    set_port(p, o, a, d, z, 1'b1);
    push_exp(cyc + 3, p, model_op(o, int'(a), d, z));
    tick;
    req[p] = 1'b0;
  endtask

  task automatic clear_all_model;
    for (int i = 0; i < (1<<AW); i++) mem_m[i] = '0;
  endtask

  task automatic test_reset;
    int n;
    tick;
    rst = 1'b1;
    tick;
    n_checks++;
    if (dout !== '0 || dout_valid !== '0) $display("FAIL reset_outputs: dout=%h valid=%b, expected 0/0", dout, dout_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: busy=%b, expected 1", busy);
    else n_pass++;
    rst = 1'b0;
    obs_q.delete();
    req = '1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      if (n == 100) begin
        n_checks++;
        if (ready !== '0) $display("FAIL sweep_ready: ready=%b, expected 00", ready);
        else n_pass++;
        req = '0;
      end
      tick;
    end
    req = '0;
    n_checks++;
    if (n != 256) $display("FAIL sweep_length: busy cycles=%0d, expected 256", n);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL sweep_quiet: completions=%0d, expected 0", obs_q.size());
    else n_pass++;
    clear_all_model();
  endtask

  task automatic test_clear_read;
    obs_q.delete(); exp_q.delete();
    issue(0, OP_READ, 8'h00, '0, 1'b0);
    issue(0, OP_READ, 8'hFF, '0, 1'b0);
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL clear_read_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].port !== exp_q[i].port || obs_q[i].data !== 16'h0000)
        $display("FAIL clear_read[%0d]: cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=0000",
                 i, obs_q[i].cyc, obs_q[i].port, obs_q[i].data, exp_q[i].cyc, exp_q[i].port);
      else n_pass++;
    end
  endtask

  task automatic test_priority;
    obs_q.delete(); exp_q.delete();
    set_port(0, OP_WRITE, 8'h05, 16'h1234, 1'b0, 1'b1);
    set_port(1, OP_READ, 8'h05, 16'h0000, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ready !== 2'b01) $display("FAIL prio_ready: ready=%b, expected 01", ready);
    else n_pass++;
    push_exp(cyc + 3, 0, model_op(OP_WRITE, 5, 16'h1234, 1'b0));
    tick;
    req[0] = 1'b0;
    #1;
    n_checks++;
    if (ready !== 2'b11) $display("FAIL prio_ready2: ready=%b, expected 11", ready);
    else n_pass++;
    push_exp(cyc + 3, 1, model_op(OP_READ, 5, 16'h0, 1'b0));
    tick;
    req[1] = 1'b0;
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != 2) $display("FAIL prio_count: got %0d, expected 2", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].port !== exp_q[i].port || obs_q[i].data !== exp_q[i].data)
        $display("FAIL prio[%0d]: cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].port, obs_q[i].data, exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() == 2 && obs_q[1].data !== 16'h1234) $display("FAIL prio_data: got %h, expected 1234", obs_q[1].data);
    else n_pass++;
  endtask

  task automatic test_atomics;
    obs_q.delete(); exp_q.delete();
    issue(0, OP_WRITE, 8'h10, 16'h00F0, 1'b0);
    issue(0, OP_SET,   8'h10, 16'h0003, 1'b0);
    issue(0, OP_CLR,   8'h10, 16'h0010, 1'b0);
    issue(0, OP_READ,  8'h10, 16'h0000, 1'b0);
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL atomic_count: got %0d, expected 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== exp_q[i].data)
        $display("FAIL atomic[%0d]: cyc=%0d data=%h, expected cyc=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, exp_q[i].data);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() == 4 && obs_q[3].data !== 16'h00E3) $display("FAIL atomic_final: got %h, expected 00e3", obs_q[3].data);
    else n_pass++;
  endtask

  task automatic test_zero;
    obs_q.delete(); exp_q.delete();
    issue(0, OP_WRITE, 8'h20, 16'hBEEF, 1'b0);
    issue(0, OP_READ,  8'h20, 16'h0000, 1'b1);
    issue(0, OP_READ,  8'h20, 16'h0000, 1'b0);
    issue(1, OP_SET,   8'h20, 16'h0100, 1'b1);
    issue(1, OP_READ,  8'h20, 16'h0000, 1'b0);
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL zero_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].port !== exp_q[i].port || obs_q[i].data !== exp_q[i].data)
        $display("FAIL zero[%0d]: cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].port, obs_q[i].data, exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic          pend [NP];
    logic [NP-1:0] exp_ready;
    logic          blk;
    int            w;
    obs_q.delete(); exp_q.delete();
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          set_port(p, 2'($urandom_range(0, 3)), 8'h40 | 8'($urandom_range(0, 7)),
                   16'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
          pend[p] = 1'b1;
        end
      end
      #1;
      exp_ready = '0;
      blk = 1'b0;
      w = -1;
      for (int p = 0; p < NP; p++) begin
        exp_ready[p] = ~blk;
        if (pend[p] && !blk) w = p;
        blk = blk | pend[p];
      end
      n_checks++;
      if (ready !== exp_ready) $display("FAIL rand_ready[%0d]: ready=%b, expected %b", c, ready, exp_ready);
      else n_pass++;
      if (w >= 0)
        push_exp(cyc + 3, w, model_op(op[2*w +: 2], int'(addr[AW*w +: AW]), din[DW*w +: DW], zero[w]));
      tick;
      if (w >= 0) begin
        req[w]  = 1'b0;
        pend[w] = 1'b0;
      end
    end
    req = '0;
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].port !== exp_q[i].port || obs_q[i].data !== exp_q[i].data)
        $display("FAIL rand[%0d]: cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].port, obs_q[i].data, exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_throughput;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      issue(0, OP_WRITE, a, {~a, a}, 1'b0);
    end
    repeat (3) tick;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      issue(0, OP_READ, a, '0, 1'b0);
    end
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != 256) $display("FAIL thru_count: got %0d, expected 256", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      a = 8'(i);
      n_checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== {~a, a})
        $display("FAIL thru[%0d]: cyc=%0d data=%h, expected cyc=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, {~a, a});
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight;
    int n;
    obs_q.delete(); exp_q.delete();
    set_port(0, OP_WRITE, 8'h30, 16'hAAAA, 1'b0, 1'b1);
    tick;
    req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      tick;
    end
    n_checks++;
    if (n != 256) $display("FAIL midreset_sweep: busy cycles=%0d, expected 256", n);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL midreset_valid: completions=%0d, expected 0", obs_q.size());
    else n_pass++;
    clear_all_model();
    obs_q.delete();
    issue(0, OP_READ, 8'h30, '0, 1'b0);
    repeat (5) tick;
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL midreset_count: got %0d, expected 1", obs_q.size());
    else if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].data !== 16'h0000)
      $display("FAIL midreset_read: cyc=%0d data=%h, expected cyc=%0d data=0000", obs_q[0].cyc, obs_q[0].data, exp_q[0].cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_priority();
    test_atomics();
    test_zero();
    test_random();
    test_throughput();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
